frame_buffer_arbiter: RTL

//  Single-port frame-buffer access controller between the VGA pixel fetch and drawing logic.

---
 rtl/frame_buffer_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer arbiter: display read > draw write > screen-clear fill.
// Define FB_CLEAR_EN to build the full-screen clear sequencer.
module frame_buffer_arbiter #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8,
   parameter int H_RES  = 640,
   parameter int V_RES  = 480
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              oob_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int PIXELS = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

   logic disp_in, wr_in;
   logic rd_go, wr_go, fill_go;
   logic rd_vld, rd_oob;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] color;

   assign disp_in = (disp_addr <= LAST);
   assign wr_in   = (wr_addr <= LAST);

   // Grants are gated by reset so every output reads as its reset value while held.
   assign rd_go = Reset_n & disp_req;
   assign wr_go = Reset_n & ~disp_req & wr_req;

`ifdef FB_CLEAR_EN
   typedef enum logic {IDLE, FILL} state_t;
   state_t state, state_nxt;

   assign clr_busy = (state == FILL);
   assign fill_go  = Reset_n & clr_busy & ~disp_req & ~wr_req;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (clr_start) state_nxt = FILL;
         FILL: if (fill_go && cnt == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Counter only advances on a fill grant and parks at LAST; restart reloads it.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt      <= '0;
         color    <= '0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= fill_go && (cnt == LAST);
         if (state == IDLE && clr_start) begin
            cnt   <= '0;
            color <= clr_color;
         end else if (fill_go && cnt != LAST) begin
            cnt <= cnt + 1'b1;
         end
      end
   end
`else
   logic unused_clr;
   assign unused_clr = ^{clr_start, clr_color};
   assign fill_go    = 1'b0;
   assign cnt        = '0;
   assign color      = '0;
   assign clr_busy   = 1'b0;
   assign clr_done   = 1'b0;
`endif

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      wr_ack    = 1'b0;
      if (rd_go) begin
         if (disp_in) mem_addr = disp_addr;
      end else if (wr_go) begin
         wr_ack = 1'b1;
         if (wr_in) begin
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
         end
      end else if (fill_go) begin
         mem_we    = 1'b1;
         mem_addr  = cnt;
         mem_wdata = color;
      end
   end

   // RAM returns data the cycle after the address; capture it one stage later.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_vld    <= 1'b0;
         rd_oob    <= 1'b0;
         disp_data <= '0;
         oob_err   <= 1'b0;
      end else begin
         rd_vld <= rd_go;
         rd_oob <= rd_go & ~disp_in;
         if (rd_vld) disp_data <= rd_oob ? '0 : mem_rdata;
         if (wr_go && !wr_in) oob_err <= 1'b1;
      end
   end

endmodule
